instruction_fetch: RTL

Sequencer that feeds the instruction register. On a fetch request from the control unit it reads one opcode byte and 0–2 operand bytes from byte-wide program memory at the program counter. It assembles them on the `opcode`/`operando1`/`operando2` buses and pulses `IR_load` for one cycle so the instruction register captures the complete 24-bit word. It owns the program counter, which the control unit can overwrite for jumps.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_pc.sv | 29 ++
 rtl/instruction_fetch.sv | 113 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer and the instruction register.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_OP,
    RD_A1,
    RD_A2,
    DONE
  } fetch_state_e;

  localparam int OPLEN_MSB = 7;
  localparam int OPLEN_LSB = 6;
  localparam int INSTR_W   = 24;

  // Operand count encoded in the opcode; 2 and 3 both mean two operands.
  function automatic logic [1:0] op_len(input logic [7:0] op);
    return op[OPLEN_MSB:OPLEN_LSB];
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter: load has priority over increment; wraps modulo 2^ADDR_W.
module fetch_pc #(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load)     pc_d = pc_in;
    else if (inc) pc_d = pc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch sequencer: reads opcode plus 0-2 operand bytes at PC and pulses IR_load
// once the full instruction word is assembled.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic [7:0]        opcode,
  output logic [7:0]        operando1,
  output logic [7:0]        operando2,
  output logic              IR_load,
  output logic              busy,
  output logic [ADDR_W-1:0] pc_out
);

  fetch_state_e state_d, state_q;
  logic [7:0]   opcode_d, opcode_q;
  logic [7:0]   op1_d, op1_q;
  logic [7:0]   op2_d, op2_q;
  logic         mem_rd_d, mem_rd_q;
  logic         ir_load_d, ir_load_q;
  logic         busy_d, busy_q;
  logic         pc_ld, pc_inc;
  logic [ADDR_W-1:0] pc;

  fetch_pc #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (pc_ld),
    .inc   (pc_inc),
    .pc_in (pc_in),
    .pc    (pc)
  );

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        pc_ld = pc_load;
        if (start) state_d = RD_OP;
      end
      RD_OP: if (mem_ack) begin
        pc_inc   = 1'b1;
        opcode_d = mem_data;
        op1_d    = '0;
        op2_d    = '0;
        state_d  = (op_len(mem_data) == 2'd0) ? DONE : RD_A1;
      end
      RD_A1: if (mem_ack) begin
        pc_inc  = 1'b1;
        op1_d   = mem_data;
        state_d = (op_len(opcode_q) == 2'd1) ? DONE : RD_A2;
      end
      RD_A2: if (mem_ack) begin
        pc_inc  = 1'b1;
        op2_d   = mem_data;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it.
    mem_rd_d  = (state_d == RD_OP) || (state_d == RD_A1) || (state_d == RD_A2);
    busy_d    = (state_d != IDLE);
    ir_load_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      opcode_q  <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      mem_rd_q  <= 1'b0;
      ir_load_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      mem_rd_q  <= mem_rd_d;
      ir_load_q <= ir_load_d;
      busy_q    <= busy_d;
    end
  end

  // Address bus is quiet outside reads so it reads 0 in reset regardless of RESET_PC.
  assign mem_addr  = mem_rd_q ? pc : '0;
  assign mem_rd    = mem_rd_q;
  assign opcode    = opcode_q;
  assign operando1 = op1_q;
  assign operando2 = op2_q;
  assign IR_load   = ir_load_q;
  assign busy      = busy_q;
  assign pc_out    = pc;

endmodule
